instr_fetch_unit: RTL

- Sits between the program ROM/instruction bus and the CPU core. It takes the core's current PC and returns the instruction at that PC.
- Prefetches sequential instructions from a req/ack instruction memory into a small FIFO tagged with PCs.
- When the core's PC departs from the prefetched stream (jump, taken branch), it flushes the FIFO and redirects fetch.
- Gives the single-cycle core a valid/stall indication, so the ROM may have variable latency.

---
 rtl/instr_fetch_unit_if.sv | 11 +
 rtl/instr_fetch_unit.sv | 125 ++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and the program ROM (slave).
// At most one request is outstanding; addr is held stable from req rising until ack.
interface instr_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// Sequential instruction prefetcher with a PC-tagged FIFO.
// When the core's PC leaves the prefetched stream, the FIFO is flushed and fetch is redirected.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [31:0]               i_pc,
  input  logic                      i_pc_advance,
  output logic [31:0]               o_instruction,
  output logic                      o_instr_valid,
  output logic                      o_stall,
  output logic [15:0]               o_redirect_count,
  instr_fetch_unit_if.master        mem
);

  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] CntFull = (PtrW+1)'(FIFO_DEPTH);
  localparam logic [PtrW:0] CntOne  = (PtrW+1)'(1);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
  localparam logic [31:0] Nop     = 32'h0000_0013;

  localparam logic StFetch = 1'b0;
  localparam logic StDrain = 1'b1;

  logic            state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     drain_addr_q, drain_addr_d;
  logic [PtrW:0]   cnt_q, cnt_d;
  logic [PtrW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [15:0]     redirect_cnt_q, redirect_cnt_d;

  logic [31:0] pc_q    [FIFO_DEPTH];
  logic [31:0] instr_q [FIFO_DEPTH];

  logic        empty, redirect, valid, pop, push, fetch_req;
  logic [31:0] head_pc, expected_pc;

  assign empty       = (cnt_q == '0);
  assign head_pc     = pc_q[rd_q];
  assign expected_pc = empty ? fetch_pc_q : head_pc;
  assign redirect    = (i_pc != expected_pc);
  assign valid       = !empty && (head_pc == i_pc);
  assign pop         = valid && i_pc_advance && !redirect;
  assign fetch_req   = (cnt_q < CntFull) || pop;

  // Request is forced low during reset so an in-flight transfer is simply abandoned.
  assign mem.req  = !i_reset && ((state_q == StDrain) || fetch_req);
  assign mem.addr = (state_q == StDrain) ? drain_addr_q : fetch_pc_q;
  assign push     = (state_q == StFetch) && mem.req && mem.ack && !redirect;

  assign o_instr_valid    = valid;
  assign o_stall          = !valid;
  assign o_instruction    = valid ? instr_q[rd_q] : Nop;
  assign o_redirect_count = redirect_cnt_q;

  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    drain_addr_d   = drain_addr_q;
    cnt_d          = cnt_q;
    rd_d           = rd_q;
    wr_d           = wr_q;
    redirect_cnt_d = redirect_cnt_q;
    if (redirect) begin
      fetch_pc_d = i_pc;
      cnt_d      = '0;
      rd_d       = '0;
      wr_d       = '0;
      if (redirect_cnt_q != 16'hFFFF) redirect_cnt_d = redirect_cnt_q + 16'd1;
      if (state_q == StFetch) begin
        // A pending, unacked request must still complete; park its address and drain it.
        if (mem.req && !mem.ack) begin
          state_d      = StDrain;
          drain_addr_d = fetch_pc_q;
        end
      end else if (mem.ack) begin
        state_d = StFetch;
      end
    end else if (state_q == StDrain) begin
      if (mem.ack) state_d = StFetch;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_d       = wr_q + PtrOne;
      end
      if (pop) rd_d = rd_q + PtrOne;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CntOne;
        2'b01:   cnt_d = cnt_q - CntOne;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q        <= StFetch;
      fetch_pc_q     <= RESET_PC;
      drain_addr_q   <= RESET_PC;
      cnt_q          <= '0;
      rd_q           <= '0;
      wr_q           <= '0;
      redirect_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      fetch_pc_q     <= fetch_pc_d;
      drain_addr_q   <= drain_addr_d;
      cnt_q          <= cnt_d;
      rd_q           <= rd_d;
      wr_q           <= wr_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  // Storage needs no reset: entries are only read while the count says they are live.
  always_ff @(posedge i_clk) begin
    if (push) begin
      pc_q[wr_q]    <= fetch_pc_q;
      instr_q[wr_q] <= mem.rdata;
    end
  end

endmodule
